rgb_pwm_monitor: RTL and testbench



---
 rtl/rgb_pwm_monitor_if.sv | 40 ++++
 rtl/rgb_pwm_monitor.sv | 174 +++++++++++++++++
 tb/tb_rgb_pwm_monitor.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_monitor_if.sv
// rgb_pwm_monitor_if: enable, PWM LED lines and per-window duty results of
// the RGB PWM monitor. The per-channel stuck flags exist only when
// PWM_MONITOR_STUCK_EN is defined.
interface rgb_pwm_monitor_if #(
  parameter int CW = 11
);
  logic          en;
  logic          pwm_r;
  logic          pwm_g;
  logic          pwm_b;
  logic [CW-1:0] duty_r;
  logic [CW-1:0] duty_g;
  logic [CW-1:0] duty_b;
  logic          valid;
`ifdef PWM_MONITOR_STUCK_EN
  logic          stuck_r;
  logic          stuck_g;
  logic          stuck_b;

  modport master (
    output en, pwm_r, pwm_g, pwm_b,
    input  duty_r, duty_g, duty_b, valid, stuck_r, stuck_g, stuck_b
  );

  modport slave (
    input  en, pwm_r, pwm_g, pwm_b,
    output duty_r, duty_g, duty_b, valid, stuck_r, stuck_g, stuck_b
  );
`else
  modport master (
    output en, pwm_r, pwm_g, pwm_b,
    input  duty_r, duty_g, duty_b, valid
  );

  modport slave (
    input  en, pwm_r, pwm_g, pwm_b,
    output duty_r, duty_g, duty_b, valid
  );
`endif
endinterface

// File: rtl/rgb_pwm_monitor.sv
// rgb_pwm_monitor: samples the three PWM LED lines through two-flop
// synchronizers and counts lit cycles per channel over back-to-back windows
// of WINDOW clocks. At the end of each window the counts are latched into
// duty_r/g/b and valid pulses for one cycle.
// Optional feature macro: PWM_MONITOR_STUCK_EN adds per-channel stuck flags
// that set after STUCK_WINDOWS consecutive windows without a lit transition.
// Channel bit order inside this module: [2] = red, [1] = green, [0] = blue.
module rgb_pwm_monitor #(
  parameter int WINDOW        = 1200,
  parameter bit ACTIVE_LOW    = 1'b1
`ifdef PWM_MONITOR_STUCK_EN
  ,
  parameter int STUCK_WINDOWS = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  rgb_pwm_monitor_if.slave mon
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(WINDOW - 1);
  // Synchronizers reset to the unlit pin level so no false lit cycles appear
  localparam logic [2:0] UNLIT_PINS = {3{ACTIVE_LOW}};

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_sample;
  logic [2:0]    pin_meta;
  logic [2:0]    pin_sync;
  logic [2:0]    lit;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] acc  [3];
  logic [CW-1:0] duty [3];
  logic          valid_q;

  // Two-flop synchronizer per channel, free-running regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_meta <= UNLIT_PINS;
      pin_sync <= UNLIT_PINS;
    end else begin
      pin_meta <= {mon.pwm_r, mon.pwm_g, mon.pwm_b};
      pin_sync <= pin_meta;
    end
  end

  assign lit = ACTIVE_LOW ? ~pin_sync : pin_sync;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; dropping en aborts the window unless it is the last sample
  always_comb begin
    state_nxt   = state;
    last_sample = 1'b0;
    case (state)
      IDLE: begin
        if (mon.en) begin
          state_nxt = MEAS;
        end
      end
      MEAS: begin
        last_sample = (win_cnt == LAST_SAMPLE);
        if (!mon.en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window counter, lit accumulators and latched duty results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc[i]  <= '0;
        duty[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      if (state == IDLE) begin
        win_cnt <= '0;
        for (int i = 0; i < 3; i++) begin
          acc[i] <= '0;
        end
      end else if (last_sample) begin
        win_cnt <= '0;
        valid_q <= 1'b1;
        for (int i = 0; i < 3; i++) begin
          duty[i] <= acc[i] + {{(CW-1){1'b0}}, lit[i]};
          acc[i]  <= '0;
        end
      end else begin
        win_cnt <= win_cnt + 1'b1;
        for (int i = 0; i < 3; i++) begin
          acc[i] <= acc[i] + {{(CW-1){1'b0}}, lit[i]};
        end
      end
    end
  end

  assign mon.duty_r = duty[2];
  assign mon.duty_g = duty[1];
  assign mon.duty_b = duty[0];
  assign mon.valid  = valid_q;

`ifdef PWM_MONITOR_STUCK_EN
  localparam int SW = $clog2(STUCK_WINDOWS + 1);
  localparam logic [SW-1:0] QUIET_SAT = SW'(STUCK_WINDOWS);

  logic [2:0]    lit_prev;
  logic [2:0]    edge_seen;
  logic [2:0]    win_edge;
  logic [2:0]    stuck_q;
  logic [SW-1:0] quiet_cnt [3];

  // A window has an edge if one was seen earlier or lit changes right now
  assign win_edge = edge_seen | (lit ^ lit_prev);

  // Edge tracking and saturating count of edge-free windows per channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lit_prev  <= '0;
      edge_seen <= '0;
      stuck_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        quiet_cnt[i] <= '0;
      end
    end else begin
      lit_prev <= lit;
      if (state == IDLE) begin
        edge_seen <= '0;
        for (int i = 0; i < 3; i++) begin
          quiet_cnt[i] <= '0;
        end
      end else if (last_sample) begin
        edge_seen <= '0;
        for (int i = 0; i < 3; i++) begin
          if (win_edge[i]) begin
            quiet_cnt[i] <= '0;
            stuck_q[i]   <= 1'b0;
          end else if (quiet_cnt[i] != QUIET_SAT) begin
            quiet_cnt[i] <= quiet_cnt[i] + 1'b1;
            if (quiet_cnt[i] == QUIET_SAT - 1'b1) begin
              stuck_q[i] <= 1'b1;
            end
          end
        end
      end else begin
        edge_seen <= win_edge;
      end
    end
  end

  assign mon.stuck_r = stuck_q[2];
  assign mon.stuck_g = stuck_q[1];
  assign mon.stuck_b = stuck_q[0];
`endif

endmodule

// File: tb/tb_rgb_pwm_monitor.sv
// tb_rgb_pwm_monitor: two monitors with WINDOW=100, one active-high and one
// active-low. The active-low instance is fed the inverted pins, so both must
// report identical results, which a window-level reference model predicts.
`timescale 1ns/1ps
module tb_rgb_pwm_monitor;

  localparam int WINDOW        = 100;
  localparam int CW            = $clog2(WINDOW + 1);
  localparam int STUCK_WINDOWS = 4;

  typedef struct {
    bit         en;
    logic [2:0] lvl;
    int         cycles;
    int         exp_valids;
    int         exp_r;
    int         exp_g;
    int         exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic [2:0] pin = 3'b000;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  int         pat_mode = 0;
  logic [2:0] lvl      = 3'b000;
  int         hi_len [3];
  int         rnd_duty [3];
  int         phase    = 0;

  always #5 clk = ~clk;

  rgb_pwm_monitor_if #(.CW(CW)) if_hi ();
  rgb_pwm_monitor_if #(.CW(CW)) if_lo ();

  assign if_hi.en    = en;
  assign if_hi.pwm_r = pin[2];
  assign if_hi.pwm_g = pin[1];
  assign if_hi.pwm_b = pin[0];
  assign if_lo.en    = en;
  assign if_lo.pwm_r = ~pin[2];
  assign if_lo.pwm_g = ~pin[1];
  assign if_lo.pwm_b = ~pin[0];

  rgb_pwm_monitor #(.WINDOW(WINDOW), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk),
    .rst (rst),
    .mon (if_hi)
  );

  rgb_pwm_monitor #(.WINDOW(WINDOW), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk (clk),
    .rst (rst),
    .mon (if_lo)
  );

  task automatic checkOutput(input string name, input int got, input int expected);
    n_checks++;
    if (got !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, expected, $time);
    end
  endtask

  // Pin generator: static levels, periodic pattern or random, changed 1ns after posedge
  always @(posedge clk) begin
    #1;
    case (pat_mode)
      0: pin = lvl;
      1: begin
        for (int c = 0; c < 3; c++) pin[c] = (phase < hi_len[c]);
        phase = (phase + 1) % WINDOW;
      end
      default: begin
        for (int c = 0; c < 3; c++) pin[c] = ($urandom_range(0, 99) < rnd_duty[c]);
      end
    endcase
  end

  // Reference model: lit history, window sums, edge-free window counts
  logic [2:0] hist [3];
  bit         m_meas;
  int         m_cnt;
  int         m_sum [3];
  int         m_duty [3];
  bit         m_valid;
  bit [2:0]   m_edge;
  int         m_quiet [3];
  bit [2:0]   m_stuck;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        hist[c] = 3'b000; m_sum[c] = 0; m_duty[c] = 0; m_quiet[c] = 0;
      end
      m_meas = 0; m_cnt = 0; m_valid = 0; m_edge = '0; m_stuck = '0;
    end else begin
      logic [2:0] lit_now;
      logic [2:0] lit_old;
      lit_now = hist[1];
      lit_old = hist[2];
      m_valid = 0;
      if (m_meas) begin
        m_cnt++;
        for (int c = 0; c < 3; c++) begin
          m_sum[c] += int'(lit_now[c]);
          if (lit_now[c] != lit_old[c]) m_edge[c] = 1'b1;
        end
        if (m_cnt == WINDOW) begin
          m_valid = 1;
          for (int c = 0; c < 3; c++) begin
            m_duty[c] = m_sum[c];
            m_sum[c]  = 0;
            if (m_edge[c]) begin
              m_quiet[c] = 0;
              m_stuck[c] = 1'b0;
            end else begin
              if (m_quiet[c] < STUCK_WINDOWS) m_quiet[c]++;
              if (m_quiet[c] == STUCK_WINDOWS) m_stuck[c] = 1'b1;
            end
          end
          m_cnt  = 0;
          m_edge = '0;
        end
        if (!en) begin
          m_meas = 0; m_cnt = 0; m_edge = '0;
          for (int c = 0; c < 3; c++) begin
            m_sum[c] = 0; m_quiet[c] = 0;
          end
        end
      end else if (en) begin
        m_meas = 1;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pin;
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("hi.duty_r", int'(if_hi.duty_r), m_duty[2]);
      checkOutput("hi.duty_g", int'(if_hi.duty_g), m_duty[1]);
      checkOutput("hi.duty_b", int'(if_hi.duty_b), m_duty[0]);
      checkOutput("hi.valid", int'(if_hi.valid), int'(m_valid));
      checkOutput("lo.duty_r", int'(if_lo.duty_r), m_duty[2]);
      checkOutput("lo.duty_g", int'(if_lo.duty_g), m_duty[1]);
      checkOutput("lo.duty_b", int'(if_lo.duty_b), m_duty[0]);
      checkOutput("lo.valid", int'(if_lo.valid), int'(m_valid));
`ifdef PWM_MONITOR_STUCK_EN
      checkOutput("hi.stuck_r", int'(if_hi.stuck_r), int'(m_stuck[2]));
      checkOutput("hi.stuck_g", int'(if_hi.stuck_g), int'(m_stuck[1]));
      checkOutput("hi.stuck_b", int'(if_hi.stuck_b), int'(m_stuck[0]));
      checkOutput("lo.stuck_r", int'(if_lo.stuck_r), int'(m_stuck[2]));
      checkOutput("lo.stuck_g", int'(if_lo.stuck_g), int'(m_stuck[1]));
      checkOutput("lo.stuck_b", int'(if_lo.stuck_b), int'(m_stuck[0]));
`endif
    end
  end

  task automatic applyStimulus(input vec_t v, output int nvalid);
    nvalid   = 0;
    en       = v.en;
    pat_mode = 0;
    lvl      = v.lvl;
    for (int i = 0; i < v.cycles; i++) begin
      @(negedge clk);
      if (if_hi.valid === 1'b1) nvalid++;
    end
  endtask

  task automatic wait_valid(input int max_cycles, output int waited);
    waited = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (if_hi.valid === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic check_duties(input string tag, input int r, input int g, input int b);
    checkOutput({tag, " hi.duty_r"}, int'(if_hi.duty_r), r);
    checkOutput({tag, " hi.duty_g"}, int'(if_hi.duty_g), g);
    checkOutput({tag, " hi.duty_b"}, int'(if_hi.duty_b), b);
    checkOutput({tag, " lo.duty_r"}, int'(if_lo.duty_r), r);
    checkOutput({tag, " lo.duty_g"}, int'(if_lo.duty_g), g);
    checkOutput({tag, " lo.duty_b"}, int'(if_lo.duty_b), b);
  endtask

  vec_t vecs [4];

  initial begin
    int nv;
    int waited;

    // lvl is the level seen by the active-high instance ({r,g,b}); lit = lvl
    vecs[0] = '{1'b0, 3'b101,  10, 0,   0,   0,   0};
    vecs[1] = '{1'b1, 3'b101, 320, 3, 100,   0, 100};
    vecs[2] = '{1'b1, 3'b010, 300, 3,   0, 100,   0};
    vecs[3] = '{1'b0, 3'b010,  50, 0,   0, 100,   0};

    #2 rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check_duties("reset", 0, 0, 0);
    checkOutput("reset hi.valid", int'(if_hi.valid), 0);
    checkOutput("reset lo.valid", int'(if_lo.valid), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], nv);
      checkOutput($sformatf("vec%0d valid count", i), nv, vecs[i].exp_valids);
      check_duties($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_g, vecs[i].exp_b);
    end

    // Periodic pattern: r lit 40, g lit 60, b lit 25 (active-low b pin low 25 of 100)
    hi_len[2] = 40; hi_len[1] = 60; hi_len[0] = 25;
    pat_mode  = 1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_valid(3 * WINDOW, waited);
    checkOutput("first valid latency", waited, WINDOW + 1);
    wait_valid(3 * WINDOW, waited);
    checkOutput("valid period", waited, WINDOW);
    check_duties("square", 40, 60, 25);

    // Abort at win_cnt 50, re-enable 10 cycles later
    repeat (50) @(negedge clk);
    en = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_hi.valid === 1'b1) nv++;
    end
    checkOutput("abort valid count", nv, 0);
    check_duties("abort hold", 40, 60, 25);
    en = 1'b1;
    wait_valid(3 * WINDOW, waited);
    checkOutput("re-entry valid latency", waited, WINDOW + 1);
    check_duties("re-entry", 40, 60, 25);

    // Asynchronous reset at win_cnt 70
    repeat (70) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_duties("async reset", 0, 0, 0);
    checkOutput("async reset hi.valid", int'(if_hi.valid), 0);
    checkOutput("async reset lo.valid", int'(if_lo.valid), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid(3 * WINDOW, waited);
    checkOutput("post-reset valid latency", waited, WINDOW + 1);

    // en drops exactly on the last sample cycle: window still completes
    repeat (WINDOW - 1) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("last-sample hi.valid", int'(if_hi.valid), 1);
    checkOutput("last-sample lo.valid", int'(if_lo.valid), 1);
    check_duties("last-sample", 40, 60, 25);
    nv = 0;
    for (int i = 0; i < 2 * WINDOW; i++) begin
      @(negedge clk);
      if (if_hi.valid === 1'b1) nv++;
    end
    checkOutput("idle after last-sample valid count", nv, 0);

`ifdef PWM_MONITOR_STUCK_EN
    // Green held at 0 from before enable; stuck after the 4th window
    hi_len[1] = 0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      wait_valid(3 * WINDOW, waited);
      checkOutput($sformatf("stuck window %0d hi.stuck_g", w), int'(if_hi.stuck_g), (w == 4) ? 1 : 0);
      checkOutput($sformatf("stuck window %0d lo.stuck_g", w), int'(if_lo.stuck_g), (w == 4) ? 1 : 0);
    end
    checkOutput("stuck hi.stuck_r", int'(if_hi.stuck_r), 0);
    repeat (50) @(negedge clk);
    hi_len[1] = WINDOW;
    wait_valid(3 * WINDOW, waited);
    checkOutput("toggle clears hi.stuck_g", int'(if_hi.stuck_g), 0);
    checkOutput("toggle clears lo.stuck_g", int'(if_lo.stuck_g), 0);
    en = 1'b0;
    repeat (5) @(negedge clk);
`endif

    // Randomized pins and enable, checked by the model every cycle
    pat_mode = 2;
    en       = 1'b1;
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 3; c++) rnd_duty[c] = $urandom_range(0, 10) * 10;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (en && $urandom_range(0, 299) == 0) en = 1'b0;
        else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      end
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
